// File: rtl/wishbone_host_master_if.sv
// Wishbone bus bundle between the SD host master and the controller's slave port.
// Signal names follow the master's point of view.
interface wishbone_host_master_if;
    logic         strobe_o;
    logic         we_o;
    logic [4:0]   adr_o;
    logic [127:0] wb_data_o;
    logic [127:0] wb_data_i;
    logic         ack_i;
    logic         error_i;

    modport master (
        output strobe_o,
        output we_o,
        output adr_o,
        output wb_data_o,
        input  wb_data_i,
        input  ack_i,
        input  error_i
    );

    modport slave (
        input  strobe_o,
        input  we_o,
        input  adr_o,
        input  wb_data_o,
        output wb_data_i,
        output ack_i,
        output error_i
    );
endinterface

// File: rtl/wishbone_host_master.sv
// Single-transfer Wishbone master for the SD host controller slave port.
// One request in, one response out; execute addresses use a two-phase ack.
module wishbone_host_master #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [4:0]   req_adr,
    input  logic [127:0] req_data,
    output logic         rsp_valid,
    output logic [127:0] rsp_data,
    output logic         rsp_error,
    output logic         rsp_timeout,
    wishbone_host_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        EXEC_LOW,
        EXEC_WAIT,
        RESP
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          strobe_q, strobe_d;
    logic          we_q, we_d;
    logic [4:0]    adr_q, adr_d;
    logic [127:0]  wdat_q, wdat_d;
    logic          rsp_valid_d;
    logic [127:0]  rsp_data_d;
    logic          rsp_error_d;
    logic          rsp_timeout_d;

    logic          done;
    logic [127:0]  done_data;
    logic          done_err;
    logic          done_to;
    logic          cnt_last;
    logic          cnt_first;
    logic          is_exec;

    assign cnt_last  = (cnt_q == CNT_LAST);
    assign cnt_first = (cnt_q == '0);
    assign is_exec   = we_q && ((adr_q == 5'd16) || (adr_q == 5'd19));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        strobe_d      = strobe_q;
        we_d          = we_q;
        adr_d         = adr_q;
        wdat_d        = wdat_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data;
        rsp_error_d   = rsp_error;
        rsp_timeout_d = rsp_timeout;
        done          = 1'b0;
        done_data     = '0;
        done_err      = 1'b0;
        done_to       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    adr_d    = req_adr;
                    wdat_d   = req_data;
                    strobe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                cnt_d = cnt_q + 1'b1;
                // The slave is still leaving IDLE on the first cycle.
                if (bus.ack_i && !cnt_first) begin
                    if (is_exec) begin
                        cnt_d   = '0;
                        state_d = EXEC_LOW;
                    end else begin
                        done      = 1'b1;
                        done_data = we_q ? '0 : bus.wb_data_i;
                        done_err  = bus.error_i;
                    end
                end else if (cnt_last) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    done_to  = 1'b1;
                end
            end
            EXEC_LOW: begin
                cnt_d = cnt_q + 1'b1;
                if (!bus.ack_i) begin
                    cnt_d   = '0;
                    state_d = EXEC_WAIT;
                end else if (cnt_last) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    done_to  = 1'b1;
                end
            end
            EXEC_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.ack_i) begin
                    done     = 1'b1;
                    done_err = bus.error_i;
                end else if (cnt_last) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    done_to  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            strobe_d      = 1'b0;
            we_d          = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_data_d    = done_data;
            rsp_error_d   = done_err;
            rsp_timeout_d = done_to;
            state_d       = RESP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_error   <= rsp_error_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign bus.strobe_o  = strobe_q;
    assign bus.we_o      = we_q;
    assign bus.adr_o     = adr_q;
    assign bus.wb_data_o = wdat_q;

endmodule

// File: tb/tb_wishbone_host_master.sv
// Directed bench for wishbone_host_master: a vector table of transfers plus
// hand sequences for a short-timeout instance and reset during execute.
module tb_wishbone_host_master;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid_a, req_valid_b;
    logic         req_we;
    logic [4:0]   req_adr;
    logic [127:0] req_data;
    logic         ack, err;
    logic [127:0] rdata;

    logic         ready_a, rv_a, re_a, rt_a;
    logic [127:0] rd_a;
    logic         ready_b, rv_b, re_b, rt_b;
    logic [127:0] rd_b;

    wishbone_host_master_if bus_a ();
    wishbone_host_master_if bus_b ();

    assign bus_a.ack_i     = ack;
    assign bus_a.error_i   = err;
    assign bus_a.wb_data_i = rdata;
    assign bus_b.ack_i     = ack;
    assign bus_b.error_i   = err;
    assign bus_b.wb_data_i = rdata;

    always #5 clock = ~clock;

    wishbone_host_master #(.TIMEOUT(32), .TW(6)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_adr(req_adr), .req_data(req_data),
        .rsp_valid(rv_a), .rsp_data(rd_a),
        .rsp_error(re_a), .rsp_timeout(rt_a),
        .bus(bus_a)
    );

    wishbone_host_master #(.TIMEOUT(16), .TW(5)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_adr(req_adr), .req_data(req_data),
        .rsp_valid(rv_b), .rsp_data(rd_b),
        .rsp_error(re_b), .rsp_timeout(rt_b),
        .bus(bus_b)
    );

    logic         sel;
    logic         o_ready, o_rv, o_re, o_rt, o_stb, o_we;
    logic [127:0] o_rd, o_wd;
    logic [4:0]   o_adr;

    assign o_ready = sel ? ready_b : ready_a;
    assign o_rv    = sel ? rv_b : rv_a;
    assign o_re    = sel ? re_b : re_a;
    assign o_rt    = sel ? rt_b : rt_a;
    assign o_rd    = sel ? rd_b : rd_a;
    assign o_stb   = sel ? bus_b.strobe_o : bus_a.strobe_o;
    assign o_we    = sel ? bus_b.we_o : bus_a.we_o;
    assign o_adr   = sel ? bus_b.adr_o : bus_a.adr_o;
    assign o_wd    = sel ? bus_b.wb_data_o : bus_a.wb_data_o;

    typedef struct {
        logic         we;
        logic [4:0]   adr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        logic         serr;
        int           on1;
        int           off1;
        int           on2;
        int           lat;
        logic [127:0] edata;
        logic         eerr;
        logic         eto;
    } vec_t;

    vec_t tv[12];
    vec_t tb5[2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave ack schedule, indexed by cycle k after request acceptance.
    function automatic logic ack_at(input vec_t v, input int k);
        logic a;
        a = (v.on1 != 0) && (k >= v.on1) && (k < v.off1);
        a = a || ((v.on2 != 0) && (k >= v.on2));
        return a;
    endfunction

    task automatic run(input vec_t v, input string tag);
        logic hold_bad;
        logic seen;
        int   k;
        @(negedge clock);
        req_we   = v.we;
        req_adr  = v.adr;
        req_data = v.wdata;
        rdata    = v.rdata;
        ack      = 1'b0;
        err      = 1'b0;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        @(posedge clock);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        check({tag, "_acc_stb"}, o_stb, 1'b1);
        check({tag, "_acc_bus"}, {o_we, o_adr, o_wd}, {v.we, v.adr, v.wdata});
        check({tag, "_acc_rdy"}, o_ready, 1'b0);
        hold_bad = 1'b0;
        seen     = 1'b0;
        k        = 0;
        while (!seen && k < v.lat + 5) begin
            k++;
            @(negedge clock);
            ack = ack_at(v, k);
            err = ack & v.serr;
            @(posedge clock);
            #1;
            if (o_rv) begin
                seen = 1'b1;
                check({tag, "_lat"}, 128'(k), 128'(v.lat));
                check({tag, "_stb_we"}, {o_stb, o_we}, 2'b00);
                check({tag, "_data"}, o_rd, v.edata);
                check({tag, "_err_to"}, {o_re, o_rt}, {v.eerr, v.eto});
            end else if (!o_stb || o_we !== v.we || o_adr !== v.adr ||
                         o_wd !== v.wdata) begin
                hold_bad = 1'b1;
            end
        end
        check({tag, "_rsp_seen"}, seen, 1'b1);
        check({tag, "_hold"}, hold_bad, 1'b0);
        @(negedge clock);
        ack = ack_at(v, k + 1);
        err = ack & v.serr;
        @(posedge clock);
        #1;
        check({tag, "_post"}, {o_rv, o_ready, o_stb}, 3'b010);
        check({tag, "_post_data"}, o_rd, v.edata);
    endtask

    initial begin
        logic bad;
        tv[0]  = '{1'b1, 5'd3,  128'h0123_4567_89AB_CDEF_0000_0000_0000_DEAD,
                   128'hFFFF, 1'b0, 2, 999, 0, 2, 128'h0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 5'd5,  128'h0, 128'h1234, 1'b0,
                   1, 999, 0, 2, 128'h1234, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 5'd16, 128'hC0DE, 128'h5555, 1'b0,
                   2, 3, 24, 24, 128'h0, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 5'd25, 128'h0, 128'hBEEF, 1'b1,
                   3, 999, 0, 3, 128'hBEEF, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 5'd19, 128'h19, 128'h6666, 1'b1,
                   2, 6, 9, 9, 128'h0, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 5'd16, 128'h0, 128'hA5, 1'b0,
                   2, 999, 0, 2, 128'hA5, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 5'd17, 128'hF1F0, 128'h9999, 1'b0,
                   4, 999, 0, 4, 128'h0, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 5'd7,  128'h0, 128'h3333, 1'b0,
                   0, 0, 0, 32, 128'h0, 1'b1, 1'b1};
        tv[8]  = '{1'b0, 5'd9,  128'h0, 128'h77, 1'b0,
                   32, 33, 0, 32, 128'h77, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 5'd31, 128'h31, 128'h1, 1'b1,
                   2, 999, 0, 2, 128'h0, 1'b1, 1'b0};
        tv[10] = '{1'b1, 5'd16, 128'hAA, 128'h2, 1'b0,
                   1, 2, 5, 37, 128'h0, 1'b1, 1'b1};
        tv[11] = '{1'b1, 5'd19, 128'hBB, 128'h3, 1'b0,
                   2, 3, 0, 35, 128'h0, 1'b1, 1'b1};
        tb5[0] = '{1'b0, 5'd2, 128'h0, 128'h4242, 1'b0,
                   0, 0, 0, 16, 128'h0, 1'b1, 1'b1};
        tb5[1] = '{1'b1, 5'd4, 128'h44, 128'h4242, 1'b0,
                   2, 999, 0, 2, 128'h0, 1'b0, 1'b0};

        sel         = 1'b0;
        reset       = 1'b1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_we      = 1'b0;
        req_adr     = '0;
        req_data    = '0;
        ack         = 1'b0;
        err         = 1'b0;
        rdata       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_bus", {o_stb, o_we, o_adr, o_wd}, '0);
        check("rst_rsp", {o_rv, o_re, o_rt, o_rd}, '0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("rst_ready", o_ready, 1'b1);

        for (int i = 0; i < 12; i++)
            run(tv[i], $sformatf("v%0d", i));

        sel = 1'b1;
        run(tb5[0], "to16");
        run(tb5[1], "after_to16");
        sel = 1'b0;

        // Reset while waiting for execute completion.
        @(negedge clock);
        req_we      = 1'b1;
        req_adr     = 5'd16;
        req_data    = 128'hFEED;
        req_valid_a = 1'b1;
        @(posedge clock);
        #1;
        req_valid_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            ack = (k == 2);
            @(posedge clock);
        end
        #1;
        check("mid_exec_stb", o_stb, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        ack   = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_bus", {o_stb, o_we, o_adr, o_wd}, '0);
        check("mid_rst_rsp", {o_rv, o_re, o_rt, o_rd}, '0);
        @(negedge clock);
        reset = 1'b0;
        ack   = 1'b0;
        bad   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            if (o_rv || !o_ready) bad = 1'b1;
        end
        check("post_rst_idle", bad, 1'b0);
        run(tv[1], "post_rst_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
